wf_trace_render: RTL
====================

Name: wf_trace_render

Overview:
- Consumer side of the waveform-limits interface.
- Takes the window limits (start_x/end_x/start_y/end_y) produced by the button-driven limits block and the VGA pixel scan coordinates.
- Issues sample-RAM read addresses and decides, per pixel, whether the pixel is window border, waveform trace, or background.
- Sits between the VGA timing generator, the sample RAM and the colour mux.

Parameters:
- ADDR_W, 8, sample-RAM address width; x offset into window truncated to this width.
- SAMPLE_W, 8, sample data width; sample value 0 means bottom row of window.
- BORDER, 1, border thickness in pixels (1..4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- x  in  11  current pixel column
- y  in  10  current pixel row
- pix_valid  in  1  x/y are a visible pixel this cycle
- frame_start  in  1  one-cycle pulse before first visible pixel of a frame
- start_x  in  11  window left edge (inclusive)
- end_x  in  11  window right edge (inclusive)
- start_y  in  10  window top edge (inclusive)
- end_y  in  10  window bottom edge (inclusive)
- rd_addr  out  ADDR_W  sample-RAM read address
- rd_data  in  SAMPLE_W  sample-RAM data, valid exactly 1 cycle after rd_addr
- out_valid  out  1  pixel outputs below are valid
- in_window  out  1  pixel inside window, border included
- border_on  out  1  pixel on window border
- trace_on  out  1  pixel on waveform trace

Behaviour:
- Reset: all outputs 0, latched limits 0, window_ok 0, prev_sample 0, all pipeline valids 0.
- Limit latching:
  - start_x/end_x/start_y/end_y are sampled only on the cycle frame_start=1.
  - Limit changes mid-frame have no effect until the next frame_start.
  - window_ok = (start_x < end_x) && (start_y < end_y), computed from the latched values.
  - If window_ok=0, the whole frame outputs in_window=border_on=trace_on=0; out_valid still follows pix_valid.
- Pipeline: fixed 3-cycle latency, no stalls.
  - S1 (cycle t+1): register x, y, pix_valid; rd_addr <= (x - lat_start_x)[ADDR_W-1:0].
  - S2 (t+2): rd_data valid for S1 pixel; compute rel_y = lat_end_y - y (clipped; see below).
  - S3 (t+3): register out_valid = pix_valid(t) and the three flags.
- rd_addr holds its last value when pix_valid=0 or the pixel is outside the x-range of the window.
- in_window = window_ok && start_x<=x<=end_x && start_y<=y<=end_y.
- border_on = in_window && (x-start_x < BORDER || end_x-x < BORDER || y-start_y < BORDER || end_y-y < BORDER).
- trace_on:
  - Requires in_window && !border_on.
  - Requires rel_y in [min(prev_sample, cur), max(prev_sample, cur)], where cur = min(rd_data, end_y-start_y).
  - The min/max range gives vertical connection between adjacent columns.
- prev_sample:
  - Updated to cur on each valid pixel whose x is inside the window x-range.
  - On the first window column of each row (x == start_x), prev_sample is treated as cur.
  - frame_start clears prev_sample to 0.
- border_on and trace_on are never both 1.
- Subtraction widths: differences computed 1 bit wider than the operand; negative results mean outside.
- frame_start coinciding with pix_valid: limits latch and the pixel is evaluated with the new limits.
- rst mid-frame: pipeline flushed, out_valid=0 next cycle, nothing drawn until the next frame_start.

Decomposition:
- Shared package (wf_pkg) holds: X_W=11, Y_W=10, default ADDR_W, SAMPLE_W, BORDER, and the screen extents 1280x1024. The limits block imports the same package.
- One natural sub-module: wf_window_cmp, purely combinational. Given latched limits, x, y and BORDER, it returns in_window, border_on, rel_y and x_off. It is used in S1/S2.

Test Plan:
- Reset: hold rst 4 cycles with random x/y -> all outputs 0, rd_addr=0; then frame_start with limits (100,500,50,300) -> limits latched.
- Address mapping: x=100..103 on y=150, pix_valid=1 -> rd_addr 0,1,2,3 one cycle later; out_valid rises exactly 3 cycles after the first pix_valid.
- Border: BORDER=1, limits (100,500,50,300) -> border_on=1 at (100,150), (500,150), (250,50), (250,300); border_on=0 and in_window=1 at (101,151); in_window=0 at (99,150).
- Trace:
  - RAM returns 10 for every address -> trace_on=1 only at y=290 for x 101..499.
  - RAM returns 10 then 20 -> trace_on=1 for rows 280..290 in the second column.
- Limits change mid-frame: drive start_x=200 mid-frame without frame_start -> output unchanged until the next frame_start, after which rd_addr=0 at x=200.
- Degenerate window: start_x=end_x=300 at frame_start -> whole frame in_window=border_on=trace_on=0, out_valid still tracks pix_valid.

Source files
------------

// File: rtl/wf_pkg.sv
// Shared definitions for the waveform window: coordinate widths, defaults and the limits record.
// Both the limits generator and the trace renderer import this package.
package wf_pkg;

    localparam int X_W          = 11;
    localparam int Y_W          = 10;
    localparam int ADDR_W_DEF   = 8;
    localparam int SAMPLE_W_DEF = 8;
    localparam int BORDER_DEF   = 1;
    localparam int SCREEN_W     = 1280;
    localparam int SCREEN_H     = 1024;

    typedef struct packed {
        logic [X_W-1:0] start_x;
        logic [X_W-1:0] end_x;
        logic [Y_W-1:0] start_y;
        logic [Y_W-1:0] end_y;
    } wf_limits_t;

    // A window is drawable only when it spans at least two columns and two rows.
    function automatic logic limits_ok(input wf_limits_t lim);
        return (lim.start_x < lim.end_x) && (lim.start_y < lim.end_y);
    endfunction

endpackage

// File: rtl/wf_window_cmp.sv
// Combinational window geometry: classifies one pixel against the latched limits
// and produces the column offset and the height above the window bottom.
module wf_window_cmp
    import wf_pkg::*;
#(
    parameter int BORDER = BORDER_DEF
) (
    input  wf_limits_t     lim,
    input  logic           window_ok,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output logic           in_xrange,
    output logic           in_window,
    output logic           border_on,
    output logic [Y_W-1:0] rel_y,
    output logic [X_W-1:0] x_off
);

    localparam logic [X_W:0] BORDER_X = (X_W+1)'(BORDER);
    localparam logic [Y_W:0] BORDER_Y = (Y_W+1)'(BORDER);

    logic [X_W:0] dx_l;
    logic [X_W:0] dx_r;
    logic [Y_W:0] dy_t;
    logic [Y_W:0] dy_b;

    // One extra bit on each difference: a set MSB means the pixel lies outside that edge.
    assign dx_l = {1'b0, x} - {1'b0, lim.start_x};
    assign dx_r = {1'b0, lim.end_x} - {1'b0, x};
    assign dy_t = {1'b0, y} - {1'b0, lim.start_y};
    assign dy_b = {1'b0, lim.end_y} - {1'b0, y};

    assign in_xrange = !dx_l[X_W] && !dx_r[X_W];
    assign in_window = window_ok && in_xrange && !dy_t[Y_W] && !dy_b[Y_W];
    assign border_on = in_window &&
                       ((dx_l < BORDER_X) || (dx_r < BORDER_X) ||
                        (dy_t < BORDER_Y) || (dy_b < BORDER_Y));
    assign rel_y     = dy_b[Y_W-1:0];
    assign x_off     = dx_l[X_W-1:0];

endmodule

// File: rtl/wf_trace_render.sv
// Per-pixel waveform renderer: latches window limits each frame, fetches one sample per
// column and flags border / trace / inside-window pixels with a fixed three-cycle latency.
module wf_trace_render
    import wf_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int BORDER   = BORDER_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [X_W-1:0]      x,
    input  logic [Y_W-1:0]      y,
    input  logic                pix_valid,
    input  logic                frame_start,
    input  logic [X_W-1:0]      start_x,
    input  logic [X_W-1:0]      end_x,
    input  logic [Y_W-1:0]      start_y,
    input  logic [Y_W-1:0]      end_y,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [SAMPLE_W-1:0] rd_data,
    output logic                out_valid,
    output logic                in_window,
    output logic                border_on,
    output logic                trace_on
);

    localparam int CW = (SAMPLE_W > Y_W) ? SAMPLE_W : Y_W;

    wf_limits_t     in_lim;
    wf_limits_t     lat_lim;
    wf_limits_t     eff_lim;
    logic           lat_ok;
    logic           eff_ok;
    logic           c_xrange;
    logic           c_inwin;
    logic           c_border;
    logic [Y_W-1:0] c_rel_y;
    logic [X_W-1:0] c_x_off;

    assign in_lim = '{start_x: start_x, end_x: end_x, start_y: start_y, end_y: end_y};

    // A pixel arriving together with frame_start is judged against the new limits.
    assign eff_lim = frame_start ? in_lim : lat_lim;
    assign eff_ok  = frame_start ? limits_ok(in_lim) : lat_ok;

    wf_window_cmp #(.BORDER(BORDER)) u_cmp (
        .lim       (eff_lim),
        .window_ok (eff_ok),
        .x         (x),
        .y         (y),
        .in_xrange (c_xrange),
        .in_window (c_inwin),
        .border_on (c_border),
        .rel_y     (c_rel_y),
        .x_off     (c_x_off)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_lim <= '0;
            lat_ok  <= 1'b0;
        end else if (frame_start) begin
            lat_lim <= in_lim;
            lat_ok  <= limits_ok(in_lim);
        end
    end

    logic           s1_valid, s1_inwin, s1_border, s1_xrange, s1_first;
    logic [Y_W-1:0] s1_rel_y, s1_height;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_inwin  <= 1'b0;
            s1_border <= 1'b0;
            s1_xrange <= 1'b0;
            s1_first  <= 1'b0;
            s1_rel_y  <= '0;
            s1_height <= '0;
            rd_addr   <= '0;
        end else begin
            s1_valid  <= pix_valid;
            s1_inwin  <= pix_valid && c_inwin;
            s1_border <= pix_valid && c_border;
            s1_xrange <= pix_valid && c_xrange;
            s1_first  <= (x == eff_lim.start_x);
            s1_rel_y  <= c_rel_y;
            s1_height <= eff_lim.end_y - eff_lim.start_y;
            if (pix_valid && c_xrange)
                rd_addr <= c_x_off[ADDR_W-1:0];
        end
    end

    logic           s2_valid, s2_inwin, s2_border, s2_xrange, s2_first;
    logic [Y_W-1:0] s2_rel_y, s2_height;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_inwin  <= 1'b0;
            s2_border <= 1'b0;
            s2_xrange <= 1'b0;
            s2_first  <= 1'b0;
            s2_rel_y  <= '0;
            s2_height <= '0;
        end else begin
            s2_valid  <= s1_valid;
            s2_inwin  <= s1_inwin;
            s2_border <= s1_border;
            s2_xrange <= s1_xrange;
            s2_first  <= s1_first;
            s2_rel_y  <= s1_rel_y;
            s2_height <= s1_height;
        end
    end

    logic [CW-1:0] prev_sample;
    logic [CW-1:0] data_w, height_w, rel_w, cur, prev_eff, lo, hi;

    // Sample clipped to the window height; the span to the previous column joins steep edges.
    always_comb begin
        data_w   = CW'(rd_data);
        height_w = CW'(s2_height);
        rel_w    = CW'(s2_rel_y);
        cur      = (data_w > height_w) ? height_w : data_w;
        prev_eff = s2_first ? cur : prev_sample;
        lo       = (prev_eff < cur) ? prev_eff : cur;
        hi       = (prev_eff < cur) ? cur : prev_eff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            in_window   <= 1'b0;
            border_on   <= 1'b0;
            trace_on    <= 1'b0;
            prev_sample <= '0;
        end else begin
            out_valid <= s2_valid;
            in_window <= s2_inwin;
            border_on <= s2_border;
            trace_on  <= s2_inwin && !s2_border && (rel_w >= lo) && (rel_w <= hi);
            if (frame_start)
                prev_sample <= '0;
            else if (s2_xrange)
                prev_sample <= cur;
        end
    end

endmodule
